irq_ack_ctrl: RTL and testbench

- Interrupt request/acknowledge controller. It is the return path of the processor's status/priority-encode logic.
- Captures rising edges on up to 8 source request lines into a pending register, then selects the highest-priority unmasked pending source (index 7 highest).
- Presents the selected source to the core as irq_out plus irq_vec, and runs the ack/EOI handshake.
- On core ack, decodes irq_vec back into a one-hot acknowledge pulse to the originating source.
- Gated by the interrupt-enable status bit (status[7]).

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_prio_sel.sv | 20 ++
 rtl/irq_ack_ctrl.sv | 95 +++++++++
 tb/tb_irq_ack_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt request/acknowledge controller.
package irq_pkg;

   localparam int NUM_SRC = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } irq_state_t;

   // Expands a source index into the one-hot acknowledge pattern.
   function automatic logic [NUM_SRC-1:0] onehot_decode(input logic [IDX_W-1:0] idx);
      logic [NUM_SRC-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Highest-index priority select over the eligible sources; bit 7 maps to 3'b111,
// matching the processor's 8-to-3 priority encoder.
module irq_prio_sel
   import irq_pkg::*;
(
   input  logic [NUM_SRC-1:0] eligible,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   // Ascending scan: later (higher) set bits overwrite earlier ones.
   always_comb begin
      valid = |eligible;
      idx   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (eligible[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/irq_ack_ctrl.sv
// Interrupt request/acknowledge controller: edge capture into pending, priority
// selection, and the ack/EOI handshake with the core.
module irq_ack_ctrl
   import irq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               int_en,
   input  logic [NUM_SRC-1:0] irq_req,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               cpu_ack,
   input  logic               cpu_eoi,
   output logic               irq_out,
   output logic [IDX_W-1:0]   irq_vec,
   output logic [NUM_SRC-1:0] src_ack,
   output logic [NUM_SRC-1:0] pending,
   output logic               busy
);

   irq_state_t         state;
   logic [NUM_SRC-1:0] req_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] ack_clr;
   logic               ack_take;
   logic               sel_valid;
   logic [IDX_W-1:0]   sel_idx;

   assign rise     = irq_req & ~req_q;
   assign eligible = pending & ~irq_mask;
   assign ack_take = (state == REQ) && cpu_ack;
   assign ack_clr  = ack_take ? onehot_decode(irq_vec) : '0;

   irq_prio_sel u_prio_sel (
      .eligible (eligible),
      .valid    (sel_valid),
      .idx      (sel_idx)
   );

   // A fresh edge on the acked source wins over its clear, so the OR comes last.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         pending <= '0;
      end else begin
         req_q   <= irq_req;
         pending <= (pending & ~ack_clr) | rise;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         irq_out <= 1'b0;
         irq_vec <= '0;
         src_ack <= '0;
         busy    <= 1'b0;
      end else begin
         src_ack <= '0;
         case (state)
            IDLE: begin
               if (int_en && sel_valid) begin
                  irq_vec <= sel_idx;
                  irq_out <= 1'b1;
                  state   <= REQ;
               end
            end
            // The vector stays frozen here: no preemption, mask changes ignored.
            REQ: begin
               if (cpu_ack) begin
                  state   <= SERVICE;
                  irq_out <= 1'b0;
                  busy    <= 1'b1;
                  src_ack <= onehot_decode(irq_vec);
               end else if (!int_en) begin
                  state   <= IDLE;
                  irq_out <= 1'b0;
               end
            end
            SERVICE: begin
               if (cpu_eoi) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               irq_out <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// Self-checking bench for irq_ack_ctrl: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_irq_ack_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       int_en = 1'b0;
   logic [7:0] irq_req = '0;
   logic [7:0] irq_mask = '0;
   logic       cpu_ack = 1'b0;
   logic       cpu_eoi = 1'b0;
   logic       irq_out;
   logic [2:0] irq_vec;
   logic [7:0] src_ack;
   logic [7:0] pending;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_pending = '0;
   logic [7:0] m_prev    = '0;
   logic [7:0] m_src_ack = '0;
   bit         m_present = 1'b0;
   bit         m_serve   = 1'b0;
   int         m_vec     = 0;

   logic [7:0] r_req  = '0;
   logic [7:0] r_mask = '0;

   irq_ack_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .int_en   (int_en),
      .irq_req  (irq_req),
      .irq_mask (irq_mask),
      .cpu_ack  (cpu_ack),
      .cpu_eoi  (cpu_eoi),
      .irq_out  (irq_out),
      .irq_vec  (irq_vec),
      .src_ack  (src_ack),
      .pending  (pending),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the reference model, evaluated from the inputs held at that edge.
   task automatic model_edge();
      logic [7:0] rise;
      logic [7:0] nxt;
      bit         acked;
      if (rst) begin
         m_pending = '0;
         m_prev    = '0;
         m_src_ack = '0;
         m_present = 1'b0;
         m_serve   = 1'b0;
         m_vec     = 0;
         return;
      end
      rise      = irq_req & ~m_prev;
      acked     = m_present && cpu_ack;
      nxt       = m_pending;
      m_src_ack = '0;
      if (acked) begin
         nxt[m_vec] = 1'b0;
         m_src_ack  = 8'(1 << m_vec);
      end
      nxt = nxt | rise;
      if (m_present) begin
         if (cpu_ack) begin
            m_present = 1'b0;
            m_serve   = 1'b1;
         end else if (!int_en) begin
            m_present = 1'b0;
         end
      end else if (m_serve) begin
         if (cpu_eoi) m_serve = 1'b0;
      end else if (int_en) begin
         for (int i = 7; i >= 0; i--) begin
            if (m_pending[i] && !irq_mask[i]) begin
               m_vec     = i;
               m_present = 1'b1;
               break;
            end
         end
      end
      m_pending = nxt;
      m_prev    = irq_req;
   endtask

   task automatic apply_stimulus(input logic r, input logic en, input logic [7:0] req,
                                 input logic [7:0] msk, input logic ack, input logic eoi);
      @(negedge clk);
      rst      = r;
      int_en   = en;
      irq_req  = req;
      irq_mask = msk;
      cpu_ack  = ack;
      cpu_eoi  = eoi;
      @(posedge clk);
      model_edge();
      #1;
      check_output("irq_out", 32'(irq_out), 32'(m_present));
      check_output("busy",    32'(busy),    32'(m_serve));
      check_output("irq_vec", 32'(irq_vec), 32'(m_vec));
      check_output("src_ack", 32'(src_ack), 32'(m_src_ack));
      check_output("pending", 32'(pending), 32'(m_pending));
   endtask

   initial begin
      apply_stimulus(1, 0, 8'h00, 8'h00, 0, 0);
      apply_stimulus(1, 0, 8'h00, 8'h00, 0, 0);
      check_output("reset_state", 32'({irq_out, busy, irq_vec, src_ack, pending}), 32'h0);

      // Single request on source 2
      apply_stimulus(0, 1, 8'h04, 8'h00, 0, 0);
      check_output("t1_pending", 32'(pending), 32'h04);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 0);
      check_output("t1_irq", 32'({irq_out, irq_vec}), 32'h0A);
      apply_stimulus(0, 1, 8'h00, 8'h00, 1, 0);
      check_output("t1_ack", 32'({busy, src_ack, pending}), 32'h10400);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 1);
      check_output("t1_eoi", 32'({irq_out, busy}), 32'h0);

      // Priority order 6, 5, 1
      apply_stimulus(0, 1, 8'h62, 8'h00, 0, 0);
      check_output("t2_pending", 32'(pending), 32'h62);
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(0, 1, 8'h62, 8'h00, 0, 0);
         check_output("t2_vec", 32'(irq_vec), (k == 0) ? 32'd6 : (k == 1) ? 32'd5 : 32'd1);
         apply_stimulus(0, 1, 8'h62, 8'h00, 1, 0);
         apply_stimulus(0, 1, 8'h62, 8'h00, 0, 1);
      end
      check_output("t2_drained", 32'(pending), 32'h0);

      // Masking, then unmasking the held source 7
      apply_stimulus(0, 1, 8'h00, 8'h80, 0, 0);
      apply_stimulus(0, 1, 8'h88, 8'h80, 0, 0);
      apply_stimulus(0, 1, 8'h88, 8'h80, 0, 0);
      check_output("t3_masked_vec", 32'(irq_vec), 32'd3);
      apply_stimulus(0, 1, 8'h88, 8'h80, 1, 0);
      apply_stimulus(0, 1, 8'h88, 8'h80, 0, 1);
      check_output("t3_held", 32'(pending), 32'h80);
      apply_stimulus(0, 1, 8'h88, 8'h00, 0, 0);
      check_output("t3_unmask_vec", 32'(irq_vec), 32'd7);
      apply_stimulus(0, 1, 8'h00, 8'h00, 1, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 1);
      apply_stimulus(0, 0, 8'h01, 8'h00, 0, 0);
      for (int k = 0; k < 6; k++) apply_stimulus(0, 0, 8'h01, 8'h00, 0, 0);
      check_output("t3_disabled", 32'(irq_out), 32'd0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 1, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 1);

      // Ack beats int_en fall; fresh edge on the acked source keeps pending
      apply_stimulus(0, 1, 8'h10, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h10, 8'h00, 0, 0);
      apply_stimulus(0, 0, 8'h10, 8'h00, 1, 0);
      check_output("t4_ack_vs_en", 32'({busy, src_ack}), 32'h110);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 1);
      apply_stimulus(0, 1, 8'h10, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h10, 8'h00, 1, 0);
      check_output("t4_set_wins", 32'(pending), 32'h10);
      apply_stimulus(0, 1, 8'h10, 8'h00, 0, 1);
      apply_stimulus(0, 1, 8'h10, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 1, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 1);

      // Spurious handshakes and no preemption
      apply_stimulus(0, 1, 8'h00, 8'h00, 1, 0);
      apply_stimulus(0, 1, 8'h01, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h01, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h81, 8'h00, 0, 1);
      check_output("t5_no_preempt", 32'({irq_out, irq_vec}), 32'h08);
      apply_stimulus(0, 1, 8'h81, 8'h00, 1, 0);
      apply_stimulus(0, 1, 8'h81, 8'h00, 0, 1);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 1, 0);
      apply_stimulus(0, 1, 8'h00, 8'h00, 0, 1);

      // Reset from SERVICE with pending 8'h11, then held level re-captured once
      apply_stimulus(0, 1, 8'h20, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h20, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h31, 8'h00, 0, 0);
      apply_stimulus(0, 1, 8'h31, 8'h00, 1, 0);
      check_output("t6_pre_reset", 32'({busy, pending}), 32'h111);
      apply_stimulus(1, 1, 8'h31, 8'h00, 0, 1);
      check_output("t6_reset", 32'({irq_out, busy, irq_vec, src_ack, pending}), 32'h0);
      apply_stimulus(0, 0, 8'h31, 8'h00, 0, 0);
      check_output("t6_recapture", 32'(pending), 32'h31);
      apply_stimulus(0, 0, 8'h31, 8'h00, 0, 0);

      // Random traffic
      r_req  = 8'h31;
      r_mask = '0;
      for (int k = 0; k < 3000; k++) begin
         r_req = r_req ^ 8'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) r_mask = 8'($urandom & $urandom);
         apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, r_req, r_mask,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
